sccb_responder: RTL and testbench
=================================

Name: sccb_responder

Overview:
Synthesizable SCCB/I2C target that answers the camera-configuration master. Operates on clk_PS and oversamples the open-drain SCL/SDA lines. Used in benches and in on-board loopback to check the configuration path without a camera attached. Holds a 256-entry 8-bit register file, accepts write and read transactions, and reports every committed write on a strobe port.

Parameters:
DEV_ADDR, 7'h21, 7-bit target address (write byte 0x42, read byte 0x43)
SYNC_STAGES, 2, synchronizer depth on SCL and SDA
RST_VAL, 8'h00, reset value of every register-file entry

Ports:
i_clk  in  1  clk_PS
i_rstn  in  1  db_rstn, asynchronous, active-low
i_scl  in  1  SCL pin level (pad input)
i_sda  in  1  SDA pin level (pad input)
o_sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z at pad)
o_wr  out  1  one-cycle strobe on each committed data-byte write
o_waddr  out  8  register address of the committed write
o_wdata  out  8  data of the committed write
o_busy  out  1  high from an addressed START until STOP
i_dbg_addr  in  8  bench read-back address
o_dbg_data  out  8  register file contents at i_dbg_addr (combinational)

Behaviour:
- Reset values: o_sda_oe=0, o_wr=0, o_waddr=0, o_wdata=0, o_busy=0. State=IDLE, pointer=0, all registers=RST_VAL.
- Reset asserted mid-transfer: SDA released in the same cycle; all state discarded.
- Line conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, then one history flop.
  - scl_rise / scl_fall are 1-cycle pulses.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Pin-to-event latency is SYNC_STAGES+1 cycles.
  - Master SCL high and low phases must each be ≥4 clk_PS cycles.
- Sampling rules:
  - Data bits are sampled on scl_rise, MSB first.
  - SDA is changed by the target only on scl_fall.
- FSM states and transitions:
  - IDLE: on START -> DEVADDR with bit count cleared.
  - DEVADDR: after 8 bits, if addr[7:1]==DEV_ADDR -> ACK_DEV and o_busy=1; otherwise -> IGNORE.
  - ACK_DEV: o_sda_oe=1 from the next scl_fall to the following scl_fall. Then R/W=0 -> REGADDR; R/W=1 -> RD_DATA.
  - REGADDR: after 8 bits, pointer<=byte -> ACK_REG -> WR_DATA.
  - WR_DATA: after 8 bits -> ACK_DATA. On the scl_fall that starts the ACK:
    - reg[pointer]<=byte
    - o_wr=1 for one cycle, with o_waddr=pointer and o_wdata=byte
    - pointer increments (8-bit wrap, 0xFF->0x00)
    - return to WR_DATA
  - RD_DATA: byte=reg[pointer] loaded on entry. o_sda_oe = ~bit, updated each scl_fall for 8 bits. Then release -> RD_ACK.
  - RD_ACK: sample the master bit on scl_rise. ACK(0): pointer++ -> RD_DATA. NACK(1): pointer++ -> IGNORE.
  - IGNORE: SDA released; waits for START or STOP.
- Global overrides:
  - START in any state -> DEVADDR (repeated start); pointer preserved.
  - STOP in any state -> IDLE with o_busy=0 and SDA released.
  - A partial byte on STOP is discarded; no write is committed.
- Read flow: SCCB-style reads are a write of the register address only, then STOP, then START with the read address byte. The pointer persists across the STOP.
- Port precedence: o_wr never fires in the same cycle as a START or STOP detection; the START/STOP takes precedence.

Decomposition:
- Shared package sccb_pkg:
  - state enum (IDLE, DEVADDR, ACK_DEV, REGADDR, ACK_REG, WR_DATA, ACK_DATA, RD_DATA, RD_ACK, IGNORE)
  - OV7670 default address constant 7'h21
  - RW bit position constant
- Sub-module sccb_line_sync: synchronizers, history flops, scl_rise/scl_fall/start/stop pulse generation. Instantiated once.

Test Plan:
- Write 0x42, 0x12, 0x80, STOP -> ACK on all three bytes; o_wr pulses once with o_waddr=0x12, o_wdata=0x80; o_dbg_data@0x12=0x80; o_busy low after STOP.
- Write 0x42, 0x3A, then 0x04, 0x05 with auto-increment -> two o_wr pulses at 0x3A/0x04 and 0x3B/0x05.
- Write 0x42, 0x3A, STOP; then 0x43, read byte, NACK, STOP -> target drives 0x04 MSB-first; SDA released before the master ACK bit.
- Address byte 0x60 -> no ACK (o_sda_oe stays 0 for the whole frame); no o_wr; o_busy stays 0.
- Write to 0xFF then a second data byte -> second write lands at 0x00 (pointer wrap).
- STOP after 4 bits of a data byte, and separately i_rstn low mid-ACK -> no o_wr; o_sda_oe=0 within 1 cycle of reset; registers=RST_VAL after reset.

Source files
------------

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared state encoding and constants for the SCCB responder
// Contents: sccb_state_t FSM states, OV7670 default target address, R/W bit position.
package sccb_pkg;
  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, REGADDR, ACK_REG, WR_DATA, ACK_DATA, RD_DATA, RD_ACK, IGNORE
  } sccb_state_t;
  localparam logic [6:0] OV7670_ADDR = 7'h21;
  localparam int RW_BIT = 0;
endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync: synchronizes SCL/SDA and produces registered bus-event pulses
// Ports: i_clk/i_rstn clock and async active-low reset; i_scl/i_sda pad levels;
//        o_scl_rise/o_scl_fall/o_start/o_stop one-cycle pulses; o_sda synced SDA level
//        aligned with the pulses. Pin-to-pulse latency is SYNC_STAGES+1 cycles.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic scl_s, sda_s, scl_h, sda_h;
  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];
  // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edge after reset.
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      scl_q      <= '1;
      sda_q      <= '1;
      scl_h      <= 1'b1;
      sda_h      <= 1'b1;
      o_scl_rise <= 1'b0;
      o_scl_fall <= 1'b0;
      o_start    <= 1'b0;
      o_stop     <= 1'b0;
      o_sda      <= 1'b1;
    end else begin
      scl_q      <= {scl_q[SYNC_STAGES-2:0], i_scl};
      sda_q      <= {sda_q[SYNC_STAGES-2:0], i_sda};
      scl_h      <= scl_s;
      sda_h      <= sda_s;
      o_scl_rise <= scl_s & ~scl_h;
      o_scl_fall <= ~scl_s & scl_h;
      o_start    <= scl_s & scl_h & sda_h & ~sda_s;
      o_stop     <= scl_s & scl_h & ~sda_h & sda_s;
      o_sda      <= sda_s;
    end
endmodule

// File: rtl/sccb_responder.sv
// sccb_responder: SCCB/I2C target with a 256x8 register file and write strobe
// Ports: i_clk/i_rstn clock and async active-low reset; i_scl/i_sda pad levels;
//        o_sda_oe open-drain pull-down enable; o_wr/o_waddr/o_wdata committed-write strobe;
//        o_busy addressed-transfer flag; i_dbg_addr/o_dbg_data combinational read-back.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = OV7670_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr,
  output logic [7:0] o_waddr,
  output logic [7:0] o_wdata,
  output logic       o_busy,
  input  logic [7:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);
  logic scl_rise, scl_fall, start, stop, sda;
  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_scl(i_scl), .i_sda(i_sda),
    .o_scl_rise(scl_rise), .o_scl_fall(scl_fall), .o_start(start), .o_stop(stop), .o_sda(sda)
  );
  sccb_state_t state;
  logic [3:0] cnt;
  logic [7:0] shreg, ptr, rx;
  logic rw;
  logic [7:0] regs [256];
  assign rx = {shreg[6:0], sda};
  assign o_dbg_data = regs[i_dbg_addr];
  // In the ACK states o_sda_oe doubles as the phase flag: the first scl_fall
  // pulls SDA low, the second releases it and leaves the state.
  // In RD_DATA cnt counts bits already driven; 0 means the byte is not yet loaded.
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      ptr      <= '0;
      rw       <= 1'b0;
      o_sda_oe <= 1'b0;
      o_wr     <= 1'b0;
      o_waddr  <= '0;
      o_wdata  <= '0;
      o_busy   <= 1'b0;
      for (int i = 0; i < 256; i++) regs[i] <= RST_VAL;
    end else begin
      o_wr <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        o_sda_oe <= 1'b0;
        o_busy   <= 1'b0;
      end else if (start) begin
        state    <= DEVADDR;
        cnt      <= '0;
        o_sda_oe <= 1'b0;
      end else begin
        case (state)
          DEVADDR: if (scl_rise) begin
            shreg <= rx;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              rw <= rx[RW_BIT];
              if (rx[7:1] == DEV_ADDR) begin
                state  <= ACK_DEV;
                o_busy <= 1'b1;
              end else state <= IGNORE;
            end
          end
          ACK_DEV: if (scl_fall) begin
            if (!o_sda_oe) o_sda_oe <= 1'b1;
            else if (rw) begin
              state    <= RD_DATA;
              shreg    <= {regs[ptr][6:0], 1'b0};
              o_sda_oe <= ~regs[ptr][7];
              cnt      <= 4'd1;
            end else begin
              state    <= REGADDR;
              o_sda_oe <= 1'b0;
              cnt      <= '0;
            end
          end
          REGADDR: if (scl_rise) begin
            shreg <= rx;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              ptr   <= rx;
              state <= ACK_REG;
            end
          end
          ACK_REG: if (scl_fall) begin
            if (!o_sda_oe) o_sda_oe <= 1'b1;
            else begin
              state    <= WR_DATA;
              o_sda_oe <= 1'b0;
              cnt      <= '0;
            end
          end
          WR_DATA: if (scl_rise) begin
            shreg <= rx;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) state <= ACK_DATA;
          end
          ACK_DATA: if (scl_fall) begin
            if (!o_sda_oe) begin
              o_sda_oe   <= 1'b1;
              regs[ptr]  <= shreg;
              o_wr       <= 1'b1;
              o_waddr    <= ptr;
              o_wdata    <= shreg;
              ptr        <= ptr + 8'd1;
            end else begin
              state    <= WR_DATA;
              o_sda_oe <= 1'b0;
              cnt      <= '0;
            end
          end
          RD_DATA: if (scl_fall) begin
            if (cnt == 4'd0) begin
              shreg    <= {regs[ptr][6:0], 1'b0};
              o_sda_oe <= ~regs[ptr][7];
              cnt      <= 4'd1;
            end else if (cnt == 4'd8) begin
              state    <= RD_ACK;
              o_sda_oe <= 1'b0;
            end else begin
              shreg    <= {shreg[6:0], 1'b0};
              o_sda_oe <= ~shreg[7];
              cnt      <= cnt + 4'd1;
            end
          end
          RD_ACK: if (scl_rise) begin
            ptr   <= ptr + 8'd1;
            cnt   <= '0;
            state <= sda ? IGNORE : RD_DATA;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_sccb_responder.sv
// tb_sccb_responder: directed SCCB master transactions against sccb_responder
module tb_sccb_responder;
  localparam int H = 8;
  logic clk = 1'b0, rstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic sda_bus, o_sda_oe, o_wr, o_busy;
  logic [7:0] o_waddr, o_wdata, dbg_addr, dbg_data;
  int n_cmp = 0, n_bad = 0;
  logic oe_any;
  logic [7:0] wa[$], wd[$];
  assign sda_bus = sda_m & ~o_sda_oe;
  always #5 clk = ~clk;
  sccb_responder dut (
    .i_clk(clk), .i_rstn(rstn), .i_scl(scl_m), .i_sda(sda_bus),
    .o_sda_oe(o_sda_oe), .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_busy(o_busy), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      oe_any |= o_sda_oe;
      if (o_wr) begin
        wa.push_back(o_waddr);
        wd.push_back(o_wdata);
      end
    end
  endtask
  task automatic bit_io(input logic b, output logic r);
    sda_m = b; step(H);
    scl_m = 1'b1; step(H);
    r = sda_bus;
    scl_m = 1'b0; step(2);
  endtask
  task automatic do_start;
    sda_m = 1'b1; step(2);
    scl_m = 1'b1; step(H);
    sda_m = 1'b0; step(H);
    scl_m = 1'b0; step(2);
  endtask
  task automatic do_stop;
    sda_m = 1'b0; step(H);
    scl_m = 1'b1; step(H);
    sda_m = 1'b1; step(H);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(d[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d, output logic oe9);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r);
      d[i] = r;
    end
    sda_m = nack; step(H);
    scl_m = 1'b1; step(H);
    oe9 = o_sda_oe;
    scl_m = 1'b0; step(2);
  endtask
  function automatic logic [15:0] qget(input logic [7:0] q[$], input int i);
    return (q.size() > i) ? {8'h00, q[i]} : 16'hffff;
  endfunction
  initial begin
    logic a, oe9;
    logic [7:0] d;
    dbg_addr = 8'h12;
    step(3);
    chk("rst_oe", o_sda_oe, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_waddr", o_waddr, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_reg12", dbg_data, 0);
    rstn = 1'b1; step(4);
    // single write 0x12 <= 0x80
    do_start;
    wr_byte(8'h42, a); chk("w1_ack_dev", a, 1);
    chk("w1_busy", o_busy, 1);
    wr_byte(8'h12, a); chk("w1_ack_reg", a, 1);
    wr_byte(8'h80, a); chk("w1_ack_dat", a, 1);
    do_stop;
    chk("w1_busy_stop", o_busy, 0);
    chk("w1_nwr", wa.size(), 1);
    chk("w1_waddr", qget(wa, 0), 16'h12);
    chk("w1_wdata", qget(wd, 0), 16'h80);
    dbg_addr = 8'h12; #1;
    chk("w1_reg12", dbg_data, 8'h80);
    wa.delete(); wd.delete();
    // auto-increment
    do_start;
    wr_byte(8'h42, a); wr_byte(8'h3A, a);
    wr_byte(8'h04, a); chk("w2_ack0", a, 1);
    wr_byte(8'h05, a); chk("w2_ack1", a, 1);
    do_stop;
    chk("w2_nwr", wa.size(), 2);
    chk("w2_waddr0", qget(wa, 0), 16'h3A);
    chk("w2_wdata0", qget(wd, 0), 16'h04);
    chk("w2_waddr1", qget(wa, 1), 16'h3B);
    chk("w2_wdata1", qget(wd, 1), 16'h05);
    wa.delete(); wd.delete();
    // read back via pointer set, STOP, then read address
    do_start;
    wr_byte(8'h42, a); wr_byte(8'h3A, a);
    do_stop;
    do_start;
    wr_byte(8'h43, a); chk("r1_ack_dev", a, 1);
    rd_byte(1'b1, d, oe9);
    chk("r1_data", d, 8'h04);
    chk("r1_release", oe9, 0);
    do_stop;
    do_start;
    wr_byte(8'h43, a);
    rd_byte(1'b1, d, oe9);
    chk("r2_data_inc", d, 8'h05);
    do_stop;
    chk("r_nwr", wa.size(), 0);
    // foreign address
    oe_any = 1'b0;
    do_start;
    wr_byte(8'h60, a); chk("n_ack_dev", a, 0);
    chk("n_busy", o_busy, 0);
    wr_byte(8'h12, a);
    do_stop;
    chk("n_oe_any", oe_any, 0);
    chk("n_nwr", wa.size(), 0);
    // pointer wrap
    do_start;
    wr_byte(8'h42, a); wr_byte(8'hFF, a);
    wr_byte(8'hA1, a); wr_byte(8'hA2, a);
    do_stop;
    chk("wrap_waddr0", qget(wa, 0), 16'hFF);
    chk("wrap_waddr1", qget(wa, 1), 16'h00);
    chk("wrap_wdata1", qget(wd, 1), 16'hA2);
    dbg_addr = 8'h00; #1;
    chk("wrap_reg00", dbg_data, 8'hA2);
    wa.delete(); wd.delete();
    // partial data byte aborted by STOP
    do_start;
    wr_byte(8'h42, a); wr_byte(8'h50, a);
    for (int i = 0; i < 4; i++) bit_io(1'b1, a);
    do_stop;
    chk("p_nwr", wa.size(), 0);
    dbg_addr = 8'h50; #1;
    chk("p_reg50", dbg_data, 8'h00);
    // reset asserted while the register-address ACK is driven
    do_start;
    wr_byte(8'h42, a);
    for (int i = 7; i >= 0; i--) bit_io(1'b0, a);
    sda_m = 1'b1; step(6);
    chk("x_oe_ack", o_sda_oe, 1);
    #3 rstn = 1'b0;
    #1 chk("x_oe_rst", o_sda_oe, 0);
    chk("x_busy_rst", o_busy, 0);
    dbg_addr = 8'h12; #1;
    chk("x_reg12", dbg_data, 8'h00);
    dbg_addr = 8'h3A; #1;
    chk("x_reg3a", dbg_data, 8'h00);
    scl_m = 1'b1; step(4);
    rstn = 1'b1; step(4);
    chk("x_nwr", wa.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
